// File: rtl/exe_muldiv_stage.sv
// exe_muldiv_stage: multi-cycle multiply/divide execute unit beside the ALU.
// Single-cycle registered multiply, iterative restoring divide, result held until accepted.
module exe_muldiv_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_allow,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_allow,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [TAG_W-1:0]  r_out_tag;
    logic [XLEN-1:0]   r_src1;
    logic [XLEN-1:0]   r_src2;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_result;
    logic [CW-1:0]     r_cnt;
    logic              r_neg1;
    logic              r_neg2;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_sdiv;
    logic              w_neg1;
    logic              w_neg2;
    logic              w_msgn;
    logic              w_borrow;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_div_res;
    logic [2*XLEN-1:0] w_ext1;
    logic [2*XLEN-1:0] w_ext2;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN+1:0]   w_trial;

    assign in_allow  = (r_state == S_IDLE) || (r_state == S_DONE && out_allow);
    assign w_accept  = in_valid && in_allow && !flush;
    assign busy      = r_state inside {S_MUL, S_DIV, S_FIX};
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_tag   = r_out_tag;

    // Divider works on magnitudes; negating INT_MIN yields 2^(XLEN-1) unsigned.
    assign w_sdiv = op[2] && !op[1];
    assign w_neg1 = w_sdiv && src1[XLEN-1];
    assign w_neg2 = w_sdiv && src2[XLEN-1];
    assign w_abs1 = w_neg1 ? -src1 : src1;
    assign w_abs2 = w_neg2 ? -src2 : src2;

    // One 2*XLEN multiplier; sign-extending only for MULH makes it serve all ops.
    assign w_msgn    = r_op == 2'b01;
    assign w_ext1    = {{XLEN{w_msgn && r_src1[XLEN-1]}}, r_src1};
    assign w_ext2    = {{XLEN{w_msgn && r_src2[XLEN-1]}}, r_src2};
    assign w_prod    = w_ext1 * w_ext2;
    assign w_mul_res = r_op == 2'b00 ? w_prod[XLEN-1:0] :
                       r_op == 2'b11 ? '0 : w_prod[2*XLEN-1:XLEN];

    assign w_trial   = {1'b0, r_rem, r_quo[XLEN-1]} - {2'b00, r_dvs};
    assign w_borrow  = |w_trial[XLEN+1:XLEN];
    assign w_quo     = (r_neg1 ^ r_neg2) ? -r_quo : r_quo;
    assign w_rem     = r_neg1 ? -r_rem : r_rem;
    assign w_div_res = (r_dvs == '0) ? (r_op[0] ? r_src1 : '1) : (r_op[0] ? w_rem : w_quo);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_tag       <= '0;
            r_out_tag   <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_neg1      <= 1'b0;
            r_neg2      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_result    <= w_mul_res;
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DIV: begin
                    r_rem <= w_borrow ? {r_rem[XLEN-2:0], r_quo[XLEN-1]} : w_trial[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], !w_borrow};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result    <= w_div_res;
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_allow) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: ;
            endcase
            // Accept last so a retiring DONE can launch the next op on the same edge.
            if (w_accept) begin
                r_op        <= op[1:0];
                r_tag       <= in_tag;
                r_src1      <= src1;
                r_src2      <= src2;
                r_dvs       <= w_abs2;
                r_rem       <= '0;
                r_quo       <= w_abs1;
                r_neg1      <= w_neg1;
                r_neg2      <= w_neg2;
                r_cnt       <= CW'(XLEN);
                r_out_valid <= 1'b0;
                r_state     <= op[2] ? S_DIV : S_MUL;
            end
        end
    end
endmodule

// File: tb/tb_exe_muldiv_stage.sv
// tb_exe_muldiv_stage: directed checks of exe_muldiv_stage at XLEN=32 and XLEN=16 side by side.
module tb_exe_muldiv_stage;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_allow = 1'b1;
    logic [2:0]  op = '0;
    logic [4:0]  tag = '0;
    logic [31:0] a = '0, b = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ia, ov, bsy, ia16, ov16, bsy16;
    logic [31:0] res;
    logic [15:0] res16;
    logic [4:0]  ot, ot16;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    exe_muldiv_stage #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_allow(ia),
        .op(op), .src1(a), .src2(b), .in_tag(tag), .out_valid(ov), .out_allow(out_allow),
        .result(res), .out_tag(ot), .busy(bsy)
    );

    exe_muldiv_stage #(.XLEN(16), .TAG_W(5)) u_dut16 (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_allow(ia16),
        .op(op), .src1(a16), .src2(b16), .in_tag(tag), .out_valid(ov16), .out_allow(out_allow),
        .result(res16), .out_tag(ot16), .busy(bsy16)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [15:0] x16, input logic [15:0] y16, input logic [4:0] t);
        @(negedge clk);
        op = o; a = x; b = y; a16 = x16; b16 = y16; tag = t; in_valid = 1'b1;
        chk("allow_before_accept", {ia, ia16}, 2'b11);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [15:0] x16, input logic [15:0] y16, input logic [31:0] e,
                          input logic [15:0] e16, input int lat, input int lat16, input logic [4:0] t);
        int          l32 = 0, l16 = 0;
        logic [31:0] r32 = '0;
        logic [15:0] r16 = '0;
        logic [4:0]  t32 = '0, tt16 = '0;
        drive(o, x, y, x16, y16, t);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (ov && l32 == 0) begin l32 = c; r32 = res; t32 = ot; end
            if (ov16 && l16 == 0) begin l16 = c; r16 = res16; tt16 = ot16; end
        end
        chk({nm, "_res32"}, r32, e);
        chk({nm, "_lat32"}, l32, lat);
        chk({nm, "_tag32"}, t32, t);
        chk({nm, "_res16"}, r16, e16);
        chk({nm, "_lat16"}, l16, lat16);
        chk({nm, "_tag16"}, tt16, t);
    endtask

    initial begin
        int n;
        int rises;
        logic [31:0] held;
        #2;
        chk("rst_ov", {ov, ov16}, 2'b00);
        chk("rst_busy", {bsy, bsy16}, 2'b00);
        chk("rst_res", {res, res16}, 48'h0);
        chk("rst_tag", {ot, ot16}, 10'h0);
        chk("rst_allow", {ia, ia16}, 2'b11);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op("mul",    3'b000, 32'h7, 32'hFFFF_FFFD, 16'h7, 16'hFFFD, 32'hFFFF_FFEB, 16'hFFEB, 1, 1, 5'd1);
        run_op("mulh",   3'b001, 32'h7, 32'hFFFF_FFFD, 16'h7, 16'hFFFD, 32'hFFFF_FFFF, 16'hFFFF, 1, 1, 5'd2);
        run_op("mulhu",  3'b010, 32'h7, 32'hFFFF_FFFD, 16'h7, 16'hFFFD, 32'h6, 16'h6, 1, 1, 5'd3);
        run_op("rsvd",   3'b011, 32'h7, 32'hFFFF_FFFD, 16'h7, 16'hFFFD, 32'h0, 16'h0, 1, 1, 5'd4);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h2, 16'hFFF9, 16'h2, 32'hFFFF_FFFD, 16'hFFFD, 33, 17, 5'd5);
        run_op("mod",    3'b101, 32'hFFFF_FFF9, 32'h2, 16'hFFF9, 16'h2, 32'hFFFF_FFFF, 16'hFFFF, 33, 17, 5'd6);
        run_op("div_np", 3'b100, 32'h7, 32'hFFFF_FFFE, 16'h7, 16'hFFFE, 32'hFFFF_FFFD, 16'hFFFD, 33, 17, 5'd7);
        run_op("mod_np", 3'b101, 32'h7, 32'hFFFF_FFFE, 16'h7, 16'hFFFE, 32'h1, 16'h1, 33, 17, 5'd8);
        run_op("divu",   3'b110, 32'hFFFF_FFFF, 32'h10, 16'hFFFF, 16'h10, 32'h0FFF_FFFF, 16'h0FFF, 33, 17, 5'd9);
        run_op("modu",   3'b111, 32'd100, 32'd7, 16'd100, 16'd7, 32'd2, 16'd2, 33, 17, 5'd10);
        run_op("divu_z", 3'b110, 32'h5, 32'h0, 16'h5, 16'h0, 32'hFFFF_FFFF, 16'hFFFF, 33, 17, 5'd11);
        run_op("mod_z",  3'b101, 32'h5, 32'h0, 16'h5, 16'h0, 32'h5, 16'h5, 33, 17, 5'd12);
        run_op("modn_z", 3'b101, 32'hFFFF_FFFB, 32'h0, 16'hFFFB, 16'h0, 32'hFFFF_FFFB, 16'hFFFB, 33, 17, 5'd13);
        run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 16'h8000, 16'hFFFF, 32'h8000_0000, 16'h8000, 33, 17, 5'd14);
        run_op("mod_ov", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 16'h8000, 16'hFFFF, 32'h0, 16'h0, 33, 17, 5'd15);

        // back-to-back MUL then MULH on the retiring edge
        drive(3'b000, 32'h7, 32'hFFFF_FFFD, 16'h7, 16'hFFFD, 5'd3);
        op = 3'b001; tag = 5'd4; in_valid = 1'b1;
        chk("b2b_mul_busy", bsy, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_mul_ov", ov, 1'b1);
        chk("b2b_mul_res", res, 32'hFFFF_FFEB);
        chk("b2b_mul_tag", ot, 5'd3);
        chk("b2b_allow_done", ia, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_mulh_accepted", {ov, bsy}, 2'b01);
        @(posedge clk);
        #1;
        chk("b2b_mulh_ov", ov, 1'b1);
        chk("b2b_mulh_res", res, 32'hFFFF_FFFF);
        chk("b2b_mulh_tag", ot, 5'd4);
        repeat (3) @(posedge clk);

        // backpressure: hold out_allow low for 10 cycles after out_valid
        out_allow = 1'b0;
        drive(3'b110, 32'hFFFF_FFFF, 32'h10, 16'hFFFF, 16'h10, 5'd9);
        n = 0;
        while (!ov && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp_lat", n, 33);
        held = res;
        chk("bp_res", held, 32'h0FFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {ov, ia, res, ot}, {1'b1, 1'b0, 32'h0FFF_FFFF, 5'd9});
        end
        out_allow = 1'b1;
        #1 chk("bp_release_allow", ia, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_idle", {ov, bsy, ia}, 3'b001);

        // flush during DIV iteration 5 with a simultaneous in_valid
        drive(3'b100, 32'd100, 32'd3, 16'd100, 16'd3, 5'd21);
        repeat (4) @(posedge clk);
        #1;
        chk("fl_busy_before", bsy, 1'b1);
        flush = 1'b1; in_valid = 1'b1; op = 3'b000;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        chk("fl_idle", {ov, bsy, ia}, 3'b001);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (ov) rises++;
        end
        chk("fl_no_valid", rises, 0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'b000;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        chk("fl_idle_reject", {bsy, bsy16, ov}, 3'b000);
        run_op("after_fl", 3'b100, 32'd100, 32'd3, 16'd100, 16'd3, 32'd33, 16'd33, 33, 17, 5'd22);

        // asynchronous reset mid-DIV
        drive(3'b111, 32'd1000, 32'd7, 16'd1000, 16'd7, 5'd23);
        repeat (10) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("arst_out", {ov, bsy, res, ot}, {1'b0, 1'b0, 32'h0, 5'h0});
        chk("arst_out16", {ov16, bsy16, res16, ot16}, {1'b0, 1'b0, 16'h0, 5'h0});
        chk("arst_allow", {ia, ia16}, 2'b11);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        run_op("after_rst", 3'b111, 32'd1000, 32'd7, 16'd1000, 16'd7, 32'd6, 16'd6, 33, 17, 5'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
